// File: rtl/i2c_codec_responder.sv
// ---------------------------------------------------------------------------
// i2c_codec_responder
//
// Write-only I2C target that emulates the WM8731 control port. It accepts
// 3-byte frames {dev_addr+W, reg_addr[6:0]+data[8], data[7:0]} and ACKs each
// byte. For every complete frame it emits one write strobe carrying the
// register address and the 9-bit data word. The block is used to close the
// loop on the codec initializer, and as a bus snoop that logs register writes.
//
// Ports
//   i_clk        system clock, at least 8x the SCL bit rate
//   i_rst_n      asynchronous active-low reset
//   i_sclk       SCL from the bus (asynchronous)
//   i_sdat       SDA from the bus (asynchronous)
//   o_sdat       SDA drive value (0 whenever o_oen=1)
//   o_oen        1 = drive o_sdat onto the bus (ACK slot only)
//   o_wr_valid   1-cycle pulse: a frame completed, o_wr_addr/o_wr_data valid
//   o_wr_addr    register address of the last complete frame
//   o_wr_data    register data of the last complete frame
//   o_busy       1 between START and STOP/abort
//   o_frame_err  1-cycle pulse: STOP/repeated START mid-frame, or extra byte
// ---------------------------------------------------------------------------
module i2c_codec_responder #(
    parameter logic [6:0]  DEV_ADDR    = 7'b0011010,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sclk,
    input  logic       i_sdat,
    output logic       o_sdat,
    output logic       o_oen,
    output logic       o_wr_valid,
    output logic [6:0] o_wr_addr,
    output logic [8:0] o_wr_data,
    output logic       o_busy,
    output logic       o_frame_err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ACKA,
        S_BYTE1,
        S_ACK1,
        S_BYTE2,
        S_ACK2,
        S_WAIT,
        S_NACKX
    } state_e;

    // -----------------------------------------------------------------------
    // Input synchronizers plus one history flop for edge detection. All flops
    // preset to 1 so that reset looks like an idle bus and no false START or
    // STOP is seen when reset is released.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_hist_q;
    logic                   sda_hist_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i_sclk};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i_sdat};
            scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
            sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise =  scl_s & ~scl_hist_q;
    assign scl_fall = ~scl_s &  scl_hist_q;
    // SCL must be high in both the current and previous sample, so an SDA
    // change that races a SCL edge is never mistaken for START/STOP.
    assign start_det = scl_s & scl_hist_q &  sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q &  sda_s;

    // -----------------------------------------------------------------------
    // Frame state
    // -----------------------------------------------------------------------
    state_e     state_q,     state_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic [7:0] sr_q,        sr_d;
    logic       ack_q,       ack_d;      // ACK (1) or NACK (0) for the current slot
    logic       slot_q,      slot_d;     // 1 once the ACK slot's first SCL fall passed
    logic       oen_q,       oen_d;
    logic [6:0] reg_addr_q,  reg_addr_d;
    logic       d8_q,        d8_d;
    logic [6:0] wr_addr_q,   wr_addr_d;
    logic [8:0] wr_data_q,   wr_data_d;
    logic       wr_valid_q,  wr_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       done_q,      done_d;     // frame complete: further bytes are errors

    logic [7:0] sr_shift;
    logic       mid_frame;

    assign sr_shift  = {sr_q[6:0], sda_s};
    assign mid_frame = (state_q == S_BYTE1) || (state_q == S_ACK1) || (state_q == S_BYTE2);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sr_d        = sr_q;
        ack_d       = ack_q;
        slot_d      = slot_q;
        oen_d       = oen_q;
        reg_addr_d  = reg_addr_q;
        d8_d        = d8_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        done_d      = done_q;

        if (start_det) begin
            // Repeated START restarts address reception from any state.
            frame_err_d = mid_frame;
            state_d     = S_ADDR;
            bit_cnt_d   = 3'd0;
            slot_d      = 1'b0;
            oen_d       = 1'b0;
            done_d      = 1'b0;
        end else if (stop_det) begin
            frame_err_d = mid_frame;
            state_d     = S_IDLE;
            bit_cnt_d   = 3'd0;
            slot_d      = 1'b0;
            oen_d       = 1'b0;
            done_d      = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_BYTE1, S_BYTE2: begin
                    if (scl_rise) begin
                        sr_d      = sr_shift;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            slot_d = 1'b0;
                            if (state_q == S_ADDR) begin
                                ack_d   = (sr_shift[7:1] == DEV_ADDR) && !sr_shift[0];
                                state_d = S_ACKA;
                            end else if (state_q == S_BYTE1) begin
                                reg_addr_d = sr_shift[7:1];
                                d8_d       = sr_shift[0];
                                ack_d      = 1'b1;
                                state_d    = S_ACK1;
                            end else begin
                                // Frame complete on this sample; the strobe
                                // registers out one clock later.
                                wr_addr_d  = reg_addr_q;
                                wr_data_d  = {d8_q, sr_shift};
                                wr_valid_d = 1'b1;
                                ack_d      = 1'b1;
                                state_d    = S_ACK2;
                            end
                        end
                    end
                end

                S_ACKA, S_ACK1, S_ACK2, S_NACKX: begin
                    // Drive from the SCL fall after bit 8 to the SCL fall
                    // after bit 9, so SDA only moves while SCL is low.
                    if (scl_fall) begin
                        if (!slot_q) begin
                            slot_d = 1'b1;
                            oen_d  = ack_q;
                        end else begin
                            slot_d    = 1'b0;
                            oen_d     = 1'b0;
                            bit_cnt_d = 3'd0;
                            case (state_q)
                                S_ACKA:  state_d = ack_q ? S_BYTE1 : S_WAIT;
                                S_ACK1:  state_d = S_BYTE2;
                                S_ACK2: begin
                                    state_d = S_WAIT;
                                    done_d  = 1'b1;
                                end
                                default: state_d = S_WAIT;
                            endcase
                        end
                    end
                end

                S_WAIT: begin
                    // Bytes here are not stored. After a complete frame each
                    // extra byte is flagged; after a NACKed address the rest
                    // of the transfer belongs to another target.
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            frame_err_d = done_q;
                            ack_d       = 1'b0;
                            slot_d      = 1'b0;
                            state_d     = S_NACKX;
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            sr_q        <= 8'd0;
            ack_q       <= 1'b0;
            slot_q      <= 1'b0;
            oen_q       <= 1'b0;
            reg_addr_q  <= 7'd0;
            d8_q        <= 1'b0;
            wr_addr_q   <= 7'd0;
            wr_data_q   <= 9'd0;
            wr_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            ack_q       <= ack_d;
            slot_q      <= slot_d;
            oen_q       <= oen_d;
            reg_addr_q  <= reg_addr_d;
            d8_q        <= d8_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_valid_q  <= wr_valid_d;
            frame_err_q <= frame_err_d;
            done_q      <= done_d;
        end
    end

    assign o_oen       = oen_q;
    assign o_sdat      = ~oen_q;
    assign o_wr_valid  = wr_valid_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_frame_err = frame_err_q;
    assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Testbench for i2c_codec_responder: an I2C master drives frames onto a
// wired-AND SDA line; a reference model predicts ACK bits and the stream of
// write strobes / frame errors, which a monitor process compares.
module tb_i2c_codec_responder;

    localparam logic [6:0] DEV  = 7'b0011010;
    localparam int         QCLK = 8;   // clocks per quarter SCL period

    logic       clk;
    logic       rst_n;
    logic       m_scl;
    logic       m_sda;
    logic       sda_bus;
    logic       o_sdat;
    logic       o_oen;
    logic       o_wr_valid;
    logic [6:0] o_wr_addr;
    logic [8:0] o_wr_data;
    logic       o_busy;
    logic       o_frame_err;

    assign sda_bus = m_sda & ~(o_oen & ~o_sdat);

    i2c_codec_responder #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sclk      (m_scl),
        .i_sdat      (sda_bus),
        .o_sdat      (o_sdat),
        .o_oen       (o_oen),
        .o_wr_valid  (o_wr_valid),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .o_busy      (o_busy),
        .o_frame_err (o_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         is_wr;
        logic [6:0] addr;
        logic [8:0] data;
    } ev_t;

    ev_t        exp_q[$];
    int         checks    = 0;
    int         passes    = 0;
    int         oen_seen  = 0;
    int         sdat_viol = 0;
    bit         pend_inc  = 1'b0;   // model: current frame would be incomplete
    logic [7:0] fb [0:7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push_err();
        ev_t e;
        e.is_wr = 1'b0; e.addr = '0; e.data = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_wr(input logic [6:0] a, input logic [8:0] d);
        ev_t e;
        e.is_wr = 1'b1; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe or error pulse must match the next expected event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_oen) oen_seen++;
            if (o_oen && o_sdat) sdat_viol++;
            if (o_wr_valid || o_frame_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {30'd0, o_wr_valid, o_frame_err}, 32'd0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("event_kind", 32'(o_wr_valid), 32'(e.is_wr));
                    if (e.is_wr) begin
                        chk("wr_addr", 32'(o_wr_addr), 32'(e.addr));
                        chk("wr_data", 32'(o_wr_data), 32'(e.data));
                    end
                end
            end
        end
    end

    task automatic q();
        repeat (QCLK) @(negedge clk);
    endtask

    task automatic wbit(input logic b);
        m_sda = b; q(); m_scl = 1'b1; q(); q(); m_scl = 1'b0; q();
    endtask

    task automatic rbit(output logic b);
        m_sda = 1'b1; q(); m_scl = 1'b1; q(); b = sda_bus; q(); m_scl = 1'b0; q();
    endtask

    task automatic wbyte(input logic [7:0] v, output logic ackbit);
        for (int i = 7; i >= 0; i--) wbit(v[i]);
        rbit(ackbit);
    endtask

    task automatic bus_start();
        m_sda = 1'b0; q(); m_scl = 1'b0; q();
    endtask

    task automatic bus_rstart();
        m_sda = 1'b1; q(); m_scl = 1'b1; q(); m_sda = 1'b0; q(); m_scl = 1'b0; q();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; q(); m_scl = 1'b1; q(); m_sda = 1'b1; q(); q();
    endtask

    // Reference model: a target addressed with W ACKs the address and the two
    // payload bytes; payload byte 1 = {reg[6:0], d[8]}, byte 2 = d[7:0]; any
    // further byte is NACKed and flagged; ending an addressed frame before the
    // payload is complete is flagged. Other addresses see no response at all.
    task automatic run_frame(input int n, input bit use_rs, input bit end_stop, input string tag);
        logic ab;
        bit   acked;
        acked = (fb[0][7:1] == DEV) && (fb[0][0] == 1'b0);
        if (use_rs && pend_inc) push_err();
        if (acked && n >= 3) push_wr(fb[1][7:1], {fb[1][0], fb[2]});
        for (int i = 3; i < n; i++) if (acked) push_err();
        pend_inc = acked && (n < 3);
        if (use_rs) bus_rstart(); else bus_start();
        chk({tag, "_busy_start"}, 32'(o_busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            wbyte(fb[i], ab);
            chk($sformatf("%s_ack%0d", tag, i), 32'(ab), (acked && i <= 2) ? 32'd0 : 32'd1);
        end
        if (end_stop) begin
            if (pend_inc) push_err();
            pend_inc = 1'b0;
            bus_stop();
            chk({tag, "_busy_stop"}, 32'(o_busy), 32'd0);
        end
    endtask

    task automatic drain(input string tag);
        repeat (8) @(negedge clk);
        chk({tag, "_outstanding"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic ab;
        bit   need_rs;
        int   n;
        bit   es;
        int   wcnt;

        m_scl = 1'b1;
        m_sda = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_oen",       32'(o_oen),       32'd0);
        chk("rst_sdat",      32'(o_sdat),      32'd1);
        chk("rst_wr_valid",  32'(o_wr_valid),  32'd0);
        chk("rst_frame_err", 32'(o_frame_err), 32'd0);
        chk("rst_busy",      32'(o_busy),      32'd0);
        chk("rst_wr_addr",   32'(o_wr_addr),   32'd0);
        chk("rst_wr_data",   32'(o_wr_data),   32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic frame
        fb[0] = 8'h34; fb[1] = 8'h1E; fb[2] = 8'h00;
        run_frame(3, 1'b0, 1'b1, "t1");
        drain("t1");

        // Back-to-back frames
        fb[1] = 8'h08; fb[2] = 8'h15;
        run_frame(3, 1'b0, 1'b1, "t2a");
        fb[1] = 8'h0E; fb[2] = 8'h42;
        run_frame(3, 1'b0, 1'b1, "t2b");
        drain("t2");

        // Wrong device address: never driven, outputs hold previous frame
        oen_seen = 0;
        fb[0] = 8'h36; fb[1] = 8'h10; fb[2] = 8'h19;
        run_frame(3, 1'b0, 1'b1, "t3");
        drain("t3");
        chk("t3_oen_seen",   32'(oen_seen),  32'd0);
        chk("t3_hold_addr",  32'(o_wr_addr), 32'h07);
        chk("t3_hold_data",  32'(o_wr_data), 32'h042);

        // Truncated frame ended by STOP
        fb[0] = 8'h34; fb[1] = 8'h10;
        run_frame(2, 1'b0, 1'b1, "t4");
        drain("t4");

        // Truncated frame ended by repeated START, then a full frame
        run_frame(2, 1'b0, 1'b0, "t5a");
        fb[2] = 8'h19;
        run_frame(3, 1'b1, 1'b1, "t5b");
        drain("t5");

        // Reset during the ACK slot of byte 1
        bus_start();
        wbyte(8'h34, ab);
        chk("t6_ack0", 32'(ab), 32'd0);
        for (int i = 7; i >= 0; i--) wbit(fb[1][i]);
        wcnt = 0;
        while (!o_oen && wcnt < 200) begin
            @(negedge clk);
            wcnt++;
        end
        chk("t6_oen_in_slot", 32'(o_oen), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_oen_async", 32'(o_oen),  32'd0);
        chk("t6_busy_rst",  32'(o_busy), 32'd0);
        m_sda = 1'b1; q(); m_scl = 1'b1; q();
        rst_n = 1'b1;
        pend_inc = 1'b0;
        q();
        fb[1] = 8'h12; fb[2] = 8'hA5;
        run_frame(3, 1'b0, 1'b1, "t6b");
        drain("t6");

        // Randomized frames
        need_rs = 1'b0;
        for (int f = 0; f < 30; f++) begin
            int r;
            r = $urandom % 8;
            n = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 4 : 3;
            es = (f == 29) ? 1'b1 : (($urandom % 4) != 0);
            fb[0] = (($urandom % 4) == 0) ? 8'($urandom) : 8'h34;
            for (int i = 1; i < 8; i++) fb[i] = 8'($urandom);
            run_frame(n, need_rs, es, $sformatf("rnd%0d", f));
            need_rs = !es;
        end
        drain("rnd");
        chk("sdat_when_driving", 32'(sdat_viol), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
